// File: rtl/control_unit_pkg.sv
// Shared types and constants for the SPARC V8 subset control unit.
package cu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_MEM_ADDR,
      S_MEM_DATA,
      S_MEM_WAIT,
      S_WB,
      S_UPDATE
   } state_t;

   typedef enum logic [1:0] {
      CLS_NOP,
      CLS_ALU,
      CLS_MEM
   } iclass_t;

   // Instruction field positions
   localparam int unsigned OP_HI  = 31;
   localparam int unsigned OP_LO  = 30;
   localparam int unsigned RD_HI  = 29;
   localparam int unsigned RD_LO  = 25;
   localparam int unsigned OP3_HI = 24;
   localparam int unsigned OP3_LO = 19;
   localparam int unsigned RS1_HI = 18;
   localparam int unsigned RS1_LO = 14;
   localparam int unsigned I_BIT  = 13;
   localparam int unsigned RS2_HI = 4;
   localparam int unsigned RS2_LO = 0;

   localparam logic [1:0] OP_ARITH = 2'b10;
   localparam logic [1:0] OP_MEM   = 2'b11;

   localparam logic [1:0] EXT_SIMM13 = 2'b00;
   localparam logic [1:0] EXT_IMM22  = 2'b01;
   localparam logic [1:0] EXT_DISP22 = 2'b10;
   localparam logic [1:0] EXT_DISP30 = 2'b11;

   localparam logic [1:0] ALUB_PB    = 2'b00;
   localparam logic [1:0] ALUB_EXT   = 2'b01;
   localparam logic [1:0] ALUB_FOUR  = 2'b10;
   localparam logic [1:0] ALUB_ZERO  = 2'b11;

   localparam logic [5:0] OP3_ADD   = 6'h00;
   localparam logic [5:0] OP3_ADDCC = 6'h10;
   localparam logic [5:0] OP3_LD    = 6'h00;
   localparam logic [5:0] OP3_ST    = 6'h04;

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> DataPath/RAM bus: instruction and MFC in, all enables and selects out.
interface control_unit_if;
   logic [31:0] IR_Out;
   logic        MFC;
   logic        NPC_enable;
   logic        PC_enable;
   logic        MDR_Enable;
   logic        MAR_Enable;
   logic        register_file_enable;
   logic        RAM_enable;
   logic        PSR_Enable;
   logic [1:0]  extender_select;
   logic [1:0]  ALUB_Mux_select;
   logic        MDR_Mux_select;
   logic [4:0]  in_PA;
   logic [4:0]  in_PB;
   logic [4:0]  in_PC;
   logic [5:0]  ALU_op;
   logic [5:0]  RAM_OpCode;

   modport master (
      input  IR_Out, MFC,
      output NPC_enable, PC_enable, MDR_Enable, MAR_Enable, register_file_enable,
             RAM_enable, PSR_Enable, extender_select, ALUB_Mux_select, MDR_Mux_select,
             in_PA, in_PB, in_PC, ALU_op, RAM_OpCode
   );

   modport slave (
      output IR_Out, MFC,
      input  NPC_enable, PC_enable, MDR_Enable, MAR_Enable, register_file_enable,
             RAM_enable, PSR_Enable, extender_select, ALUB_Mux_select, MDR_Mux_select,
             in_PA, in_PB, in_PC, ALU_op, RAM_OpCode
   );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational instruction classifier (module cu_decode).
// Memory ops are recognised only when CU_MEM_OPS_EN is defined.
module cu_decode
   import cu_pkg::*;
(
   input  logic [1:0] op,
   input  logic [5:0] op3,
   output iclass_t    iclass,
   output logic       is_store,
   output logic       is_cc
);

   always_comb begin
      iclass = CLS_NOP;
      if (op == OP_ARITH && (!op3[5] || op3 == 6'h25 || op3 == 6'h26 || op3 == 6'h27))
         iclass = CLS_ALU;
`ifdef CU_MEM_OPS_EN
      else if (op == OP_MEM)
         iclass = CLS_MEM;
`endif
   end

   assign is_store = op3[2];
   assign is_cc    = (op3[5:4] == 2'b01);

endmodule

// File: rtl/control_unit.sv
// Per-instruction sequencer driving all DataPath enables and selects.
// CU_MEM_OPS_EN enables the load/store states; without it op=11 runs as a NOP.
module control_unit
   import cu_pkg::*;
(
   input  logic           Clk,
   input  logic           Clr,
   control_unit_if.master bus
);

   state_t      state;
   iclass_t     iclass;
   logic        is_store;
   logic        is_cc;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [5:0]  op3;
   logic        imm;

   assign rd  = bus.IR_Out[RD_HI:RD_LO];
   assign rs1 = bus.IR_Out[RS1_HI:RS1_LO];
   assign rs2 = bus.IR_Out[RS2_HI:RS2_LO];
   assign op3 = bus.IR_Out[OP3_HI:OP3_LO];
   assign imm = bus.IR_Out[I_BIT];

   cu_decode u_decode (
      .op       (bus.IR_Out[OP_HI:OP_LO]),
      .op3      (op3),
      .iclass   (iclass),
      .is_store (is_store),
      .is_cc    (is_cc)
   );

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:   state <= S_EXEC;
            S_EXEC:   state <= (iclass == CLS_MEM) ? S_MEM_ADDR : S_UPDATE;
`ifdef CU_MEM_OPS_EN
            S_MEM_ADDR: state <= is_store ? S_MEM_DATA : S_MEM_WAIT;
            S_MEM_DATA: state <= S_MEM_WAIT;
            S_MEM_WAIT: if (bus.MFC) state <= is_store ? S_UPDATE : S_WB;
            S_WB:       state <= S_UPDATE;
`endif
            S_UPDATE: state <= S_EXEC;
            default:  state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.in_PA                = rs1;
      bus.in_PB                = rs2;
      bus.in_PC                = rd;
      bus.ALU_op               = op3;
      bus.RAM_OpCode           = op3;
      bus.extender_select      = EXT_SIMM13;
      bus.ALUB_Mux_select      = imm ? ALUB_EXT : ALUB_PB;
      bus.MDR_Mux_select       = 1'b0;
      bus.NPC_enable           = 1'b0;
      bus.PC_enable            = 1'b0;
      bus.MDR_Enable           = 1'b0;
      bus.MAR_Enable           = 1'b0;
      bus.register_file_enable = 1'b0;
      bus.RAM_enable           = 1'b0;
      bus.PSR_Enable           = 1'b0;
      case (state)
         S_EXEC: begin
            if (iclass == CLS_ALU) begin
               bus.register_file_enable = (rd != 5'd0);
               bus.PSR_Enable           = is_cc;
            end
         end
`ifdef CU_MEM_OPS_EN
         S_MEM_ADDR: begin
            bus.ALU_op     = OP3_ADD;
            bus.MAR_Enable = 1'b1;
         end
         S_MEM_DATA: begin
            bus.in_PB      = rd;
            bus.MDR_Enable = 1'b1;
         end
         S_MEM_WAIT: begin
            bus.RAM_enable = 1'b1;
            // Load data is captured in the MFC cycle itself, not a cycle later
            if (bus.MFC && !is_store) begin
               bus.MDR_Mux_select = 1'b1;
               bus.MDR_Enable     = 1'b1;
            end
         end
         S_WB: begin
            // DataPath routes MDR to write port C while in this state
            bus.in_PC                = rd;
            bus.register_file_enable = (rd != 5'd0);
         end
`endif
         S_UPDATE: begin
            bus.PC_enable  = 1'b1;
            bus.NPC_enable = 1'b1;
         end
         default: ;
      endcase
   end

`ifndef CU_MEM_OPS_EN
   logic unused_mem;
   assign unused_mem = bus.MFC ^ is_store;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expectations follow CU_MEM_OPS_EN.
module tb_control_unit;

   logic Clk;
   logic Clr;
   int unsigned pass_cnt;
   int unsigned fail_cnt;
   int unsigned total_cnt;

   control_unit_if bus ();

   control_unit dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // {NPC, PC, MDR, MAR, RF, RAM, PSR}
   function automatic logic [6:0] en_vec();
      return {bus.NPC_enable, bus.PC_enable, bus.MDR_Enable, bus.MAR_Enable,
              bus.register_file_enable, bus.RAM_enable, bus.PSR_Enable};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      pass_cnt  = 0;
      fail_cnt  = 0;
      total_cnt = 0;
      Clr        = 1'b1;
      bus.IR_Out = 32'h8280A004;
      bus.MFC    = 1'b0;

      // Reset -> IDLE
      tick();
      chk("rst_en", 32'(en_vec()), 32'h00);
      chk("rst_pa", 32'(bus.in_PA), 32'd2);
      chk("rst_alub", 32'(bus.ALUB_Mux_select), 32'd1);
      Clr = 1'b0;

      // addcc r1,r2,4
      tick();
      chk("addcc_en", 32'(en_vec()), 32'b0000101);
      chk("addcc_pa", 32'(bus.in_PA), 32'd2);
      chk("addcc_pc", 32'(bus.in_PC), 32'd1);
      chk("addcc_aluop", 32'(bus.ALU_op), 32'h10);
      chk("addcc_alub", 32'(bus.ALUB_Mux_select), 32'd1);
      chk("addcc_ext", 32'(bus.extender_select), 32'd0);
      tick();
      chk("addcc_upd_en", 32'(en_vec()), 32'b1100000);

      // add r1,r1,r2
      bus.IR_Out = 32'h82004002;
      tick();
      chk("add_en", 32'(en_vec()), 32'b0000100);
      chk("add_alub", 32'(bus.ALUB_Mux_select), 32'd0);
      chk("add_pb", 32'(bus.in_PB), 32'd2);
      chk("add_aluop", 32'(bus.ALU_op), 32'h00);
      tick();
      chk("add_upd_en", 32'(en_vec()), 32'b1100000);

      // addcc with rd=g0
      bus.IR_Out = 32'h8080A004;
      tick();
      chk("g0_en", 32'(en_vec()), 32'b0000001);
      tick();
      chk("g0_upd_en", 32'(en_vec()), 32'b1100000);

      // sethi (op=00) is a NOP; MFC high here must be ignored
      bus.IR_Out = 32'h01000000;
      bus.MFC    = 1'b1;
      tick();
      chk("nop_en", 32'(en_vec()), 32'h00);
      tick();
      chk("nop_upd_en", 32'(en_vec()), 32'b1100000);
      bus.MFC = 1'b0;

      // ld [r1+8],r3 with MFC on the third MEM_WAIT cycle
      bus.IR_Out = 32'hC6006008;
      tick();
      chk("ld_exec_en", 32'(en_vec()), 32'h00);
      tick();
`ifdef CU_MEM_OPS_EN
      chk("ld_addr_en", 32'(en_vec()), 32'b0001000);
      chk("ld_addr_aluop", 32'(bus.ALU_op), 32'h00);
      chk("ld_addr_alub", 32'(bus.ALUB_Mux_select), 32'd1);
      chk("ld_ramop", 32'(bus.RAM_OpCode), 32'h00);
      tick();
      chk("ld_wait1_en", 32'(en_vec()), 32'b0000010);
      tick();
      chk("ld_wait2_en", 32'(en_vec()), 32'b0000010);
      tick();
      bus.MFC = 1'b1;
      #1;
      chk("ld_mfc_en", 32'(en_vec()), 32'b0010010);
      chk("ld_mfc_mux", 32'(bus.MDR_Mux_select), 32'd1);
      tick();
      bus.MFC = 1'b0;
      #1;
      chk("ld_wb_en", 32'(en_vec()), 32'b0000100);
      chk("ld_wb_pc", 32'(bus.in_PC), 32'd3);
      tick();
      chk("ld_upd_en", 32'(en_vec()), 32'b1100000);

      // st r3,[r1+8] with MFC already high on MEM_WAIT entry
      bus.IR_Out = 32'hC6206008;
      tick();
      chk("st_exec_en", 32'(en_vec()), 32'h00);
      tick();
      chk("st_addr_en", 32'(en_vec()), 32'b0001000);
      bus.MFC = 1'b1;
      tick();
      chk("st_data_en", 32'(en_vec()), 32'b0010000);
      chk("st_data_pb", 32'(bus.in_PB), 32'd3);
      chk("st_data_mux", 32'(bus.MDR_Mux_select), 32'd0);
      tick();
      chk("st_wait_en", 32'(en_vec()), 32'b0000010);
      chk("st_ramop", 32'(bus.RAM_OpCode), 32'h04);
      tick();
      bus.MFC = 1'b0;
      chk("st_upd_en", 32'(en_vec()), 32'b1100000);

      // Clr during MEM_WAIT abandons the access
      bus.IR_Out = 32'hC6006008;
      tick();
      tick();
      tick();
      chk("abort_wait_en", 32'(en_vec()), 32'b0000010);
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      chk("abort_idle_en", 32'(en_vec()), 32'h00);
      tick();
      tick();
      chk("abort_restart_en", 32'(en_vec()), 32'b0001000);
`else
      chk("ld_nop_upd_en", 32'(en_vec()), 32'b1100000);
      bus.MFC = 1'b1;
      tick();
      chk("ld_nop_exec_en", 32'(en_vec()), 32'h00);
      chk("ld_nop_mux", 32'(bus.MDR_Mux_select), 32'd0);
      tick();
      chk("ld_nop_upd2_en", 32'(en_vec()), 32'b1100000);
      bus.MFC = 1'b0;
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      chk("clr_idle_en", 32'(en_vec()), 32'h00);
      tick();
      tick();
      chk("clr_restart_en", 32'(en_vec()), 32'b1100000);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
